ili_bus_ctrl: RTL and testbench

Avalon-MM slave that sequences the ILI9341 8080-style parallel bus (CS#, RS/DC, WR#, RD#, 16-bit data) for the 2.4" TFT. It replaces the per-pin PIOs (nRD, nWR, RS, CS, data) with a single timed engine. The Nios II writes a command, writes data or reads data with one bus access each, and the block stretches the access with waitrequest until the panel strobe cycle completes. It sits between the Avalon fabric and the TFT header pins; the SD-to-TFT software uses it for all panel traffic.

---
 rtl/ili_bus_pkg.sv | 27 ++
 rtl/ili_bus_if.sv | 22 ++
 rtl/ili_strobe_timer.sv | 35 +++
 rtl/ili_bus_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ili_bus_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ili_bus_pkg.sv
// Shared constants and state encoding for the ILI9341 8080-style bus engine.
package ili_bus_pkg;

    localparam logic [1:0] ADDR_CMD   = 2'd0;
    localparam logic [1:0] ADDR_DATA  = 2'd1;
    localparam logic [1:0] ADDR_RDATA = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_WR_LOW_CYC  = 2;
    localparam int DEF_WR_HIGH_CYC = 2;
    localparam int DEF_RD_LOW_CYC  = 8;
    localparam int DEF_RD_HIGH_CYC = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ili_bus_if.sv
// Avalon-MM slave port bundle between the fabric and the panel bus engine.
interface ili_bus_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata, waitrequest
    );

endinterface

// File: rtl/ili_strobe_timer.sv
// Loadable down-counter timing the strobe-low and strobe-high phases.
module ili_strobe_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!done) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ili_bus_ctrl.sv
// Avalon-MM slave that sequences one ILI9341 8080 bus cycle per access.
module ili_bus_ctrl
    import ili_bus_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WR_LOW_CYC  = DEF_WR_LOW_CYC,
    parameter int WR_HIGH_CYC = DEF_WR_HIGH_CYC,
    parameter int RD_LOW_CYC  = DEF_RD_LOW_CYC,
    parameter int RD_HIGH_CYC = DEF_RD_HIGH_CYC
) (
    input  logic              clk,
    input  logic              reset,
    ili_bus_if.slave          avs,
    output logic              lcd_cs_n,
    output logic              lcd_rs,
    output logic              lcd_wr_n,
    output logic              lcd_rd_n,
    output logic              lcd_rst_n,
    output logic [DATA_W-1:0] lcd_data_out,
    output logic              lcd_data_oe,
    input  logic [DATA_W-1:0] lcd_data_in
);

    localparam int MAX_CYC = max2(max2(WR_LOW_CYC, WR_HIGH_CYC),
                                  max2(RD_LOW_CYC, RD_HIGH_CYC));
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] WL = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WH = CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] RL = CNT_W'(RD_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RH = CNT_W'(RD_HIGH_CYC - 1);

    state_e            state_q, state_d;
    logic              dir_rd_q, dir_rd_d;
    logic              rs_q, rs_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdreg_q, rdreg_d;
    logic              rst_n_q, rst_n_d;
    logic              cs_n_q, cs_n_d;
    logic              wr_n_q, wr_n_d;
    logic              rd_n_q, rd_n_d;
    logic              oe_q, oe_d;

    logic              req, wr_req, panel, active;
    logic              t_load, t_done;
    logic [CNT_W-1:0]  t_val;
    logic [31:0]       rdata;

    assign wr_req = avs.chipselect & ~avs.write_n;
    assign req    = avs.chipselect & (~avs.write_n | ~avs.read_n);
    assign panel  = wr_req ? (avs.address == ADDR_CMD ||
                              avs.address == ADDR_DATA)
                           : (avs.address == ADDR_RDATA);

    ili_strobe_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (reset),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    always_comb begin
        state_d  = state_q;
        dir_rd_d = dir_rd_q;
        rs_d     = rs_q;
        data_d   = data_q;
        rdreg_d  = rdreg_q;
        rst_n_d  = rst_n_q;
        t_load   = 1'b0;
        t_val    = '0;
        unique case (state_q)
            IDLE: begin
                if (req && panel) begin
                    state_d  = SETUP;
                    dir_rd_d = ~wr_req;
                    rs_d     = (avs.address != ADDR_CMD);
                    data_d   = avs.writedata[DATA_W-1:0];
                end else if (req) begin
                    state_d = DONE;
                    if (wr_req && avs.address == ADDR_CTRL)
                        rst_n_d = avs.writedata[0];
                end
            end
            SETUP: begin
                state_d = STROBE;
                t_load  = 1'b1;
                t_val   = dir_rd_q ? RL : WL;
            end
            STROBE: begin
                if (t_done) begin
                    state_d = HOLD;
                    t_load  = 1'b1;
                    t_val   = dir_rd_q ? RH : WH;
                    if (dir_rd_q) rdreg_d = lcd_data_in;
                end
            end
            HOLD: begin
                if (t_done) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Pin levels follow the next state so they change on the same edge.
        active = (state_d == SETUP) || (state_d == STROBE) ||
                 (state_d == HOLD);
        cs_n_d = ~active;
        oe_d   = active & ~dir_rd_d;
        wr_n_d = ~((state_d == STROBE) & ~dir_rd_d);
        rd_n_d = ~((state_d == STROBE) & dir_rd_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            dir_rd_q <= 1'b0;
            rs_q     <= 1'b1;
            data_q   <= '0;
            rdreg_q  <= '0;
            rst_n_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_rd_q <= dir_rd_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            rdreg_q  <= rdreg_d;
            rst_n_q  <= rst_n_d;
            cs_n_q   <= cs_n_d;
            wr_n_q   <= wr_n_d;
            rd_n_q   <= rd_n_d;
            oe_q     <= oe_d;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (avs.address)
            ADDR_RDATA: rdata[DATA_W-1:0] = rdreg_q;
            ADDR_CTRL:  rdata[0]          = rst_n_q;
            default:    rdata             = '0;
        endcase
    end

    assign avs.readdata    = rdata;
    assign avs.waitrequest = req & (state_q != DONE);

    assign lcd_cs_n     = cs_n_q;
    assign lcd_rs       = rs_q;
    assign lcd_wr_n     = wr_n_q;
    assign lcd_rd_n     = rd_n_q;
    assign lcd_rst_n    = rst_n_q;
    assign lcd_data_out = data_q;
    assign lcd_data_oe  = oe_q;

endmodule

// File: tb/tb_ili_bus_ctrl.sv
// Table-driven and randomized checks of ili_bus_ctrl against a transaction model.
`timescale 1ns/1ps
module tb_ili_bus_ctrl;

    localparam int DW = 16;
    localparam int WLO = 2, WHI = 2, RLO = 8, RHI = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
    logic          lcd_rst_n, lcd_data_oe;
    logic [DW-1:0] lcd_data_out;
    logic [DW-1:0] lcd_data_in = '0;

    ili_bus_if bus();

    ili_bus_ctrl #(
        .DATA_W(DW), .WR_LOW_CYC(WLO), .WR_HIGH_CYC(WHI),
        .RD_LOW_CYC(RLO), .RD_HIGH_CYC(RHI)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .avs          (bus.slave),
        .lcd_cs_n     (lcd_cs_n),
        .lcd_rs       (lcd_rs),
        .lcd_wr_n     (lcd_wr_n),
        .lcd_rd_n     (lcd_rd_n),
        .lcd_rst_n    (lcd_rst_n),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .lcd_data_in  (lcd_data_in)
    );

    always #10 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic rst_model = 1'b0;

    typedef struct {
        int          wcyc, cs_lo, wr_lo, rd_lo, oe_hi, wr_first;
        logic [31:0] rdat;
        logic [15:0] wdat;
        logic        rs;
        bit          tmo;
    } obs_t;

    typedef struct {
        bit          wr;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [15:0] din;
        int          e_wait, e_cs, e_wr, e_rd, e_oe;
        logic [31:0] e_rdat;
        logic [15:0] e_data;
        logic        e_rs;
        logic        e_rstn;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic access(input bit wr, input logic [1:0] a,
                          input logic [31:0] wd, input logic [15:0] din,
                          output obs_t o);
        o = '{default: 0};
        o.wr_first = -1;
        o.tmo = 1'b1;
        bus.chipselect = 1'b1;
        bus.write_n    = ~wr;
        bus.read_n     = wr;
        bus.address    = a;
        bus.writedata  = wd;
        lcd_data_in    = din;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!lcd_cs_n) begin
                o.cs_lo++;
                o.rs = lcd_rs;
            end
            if (!lcd_wr_n) begin
                if (o.wr_first < 0) o.wr_first = k;
                o.wr_lo++;
                o.wdat = lcd_data_out;
            end
            if (!lcd_rd_n) o.rd_lo++;
            if (lcd_data_oe) o.oe_hi++;
            if (bus.waitrequest) begin
                o.wcyc++;
            end else begin
                o.rdat = bus.readdata;
                o.tmo = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
    endtask

    task automatic check_obs(input string tag, input obs_t o, input vec_t v);
        chk({tag, " timeout"}, 32'(o.tmo), 32'd0);
        chk({tag, " wait"}, o.wcyc, v.e_wait);
        chk({tag, " cs_lo"}, o.cs_lo, v.e_cs);
        chk({tag, " wr_lo"}, o.wr_lo, v.e_wr);
        chk({tag, " rd_lo"}, o.rd_lo, v.e_rd);
        chk({tag, " oe_hi"}, o.oe_hi, v.e_oe);
        chk({tag, " rstn"}, 32'(lcd_rst_n), 32'(v.e_rstn));
        if (!v.wr) chk({tag, " rdata"}, o.rdat, v.e_rdat);
        if (v.e_wr > 0) begin
            chk({tag, " wdata"}, 32'(o.wdat), 32'(v.e_data));
            chk({tag, " wr_first"}, o.wr_first, 2);
        end
        if (v.e_cs > 0) chk({tag, " rs"}, 32'(o.rs), 32'(v.e_rs));
    endtask

    // Expected transaction outcome from the register map and timing rules.
    function automatic vec_t model(input bit wr, input logic [1:0] a,
                                   input logic [31:0] wd,
                                   input logic [15:0] din);
        vec_t v;
        bit panel;
        int lo, hi;
        panel = wr ? (a < 2) : (a == 2);
        lo = wr ? WLO : RLO;
        hi = wr ? WHI : RHI;
        v.wr = wr; v.a = a; v.wd = wd; v.din = din;
        v.e_wait = panel ? 2 + lo + hi : 1;
        v.e_cs   = panel ? 1 + lo + hi : 0;
        v.e_wr   = (panel && wr) ? lo : 0;
        v.e_rd   = (panel && !wr) ? lo : 0;
        v.e_oe   = (panel && wr) ? 1 + lo + hi : 0;
        v.e_rdat = 32'd0;
        if (!wr && a == 2) v.e_rdat = {16'd0, din};
        if (!wr && a == 3) v.e_rdat = {31'd0, rst_model};
        v.e_data = wd[15:0];
        v.e_rs   = (a != 0);
        if (wr && a == 3) rst_model = wd[0];
        v.e_rstn = rst_model;
        return v;
    endfunction

    vec_t tbl[11];
    obs_t o;
    vec_t v;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1, 2'd3, 32'h1,    16'h0,    1,  0, 0, 0, 0,
                    32'h0,    16'h0,    1'b0, 1'b1};
        tbl[1]  = '{0, 2'd3, 32'h0,    16'h0,    1,  0, 0, 0, 0,
                    32'h1,    16'h0,    1'b0, 1'b1};
        tbl[2]  = '{1, 2'd0, 32'h2C,   16'h0,    6,  5, 2, 0, 5,
                    32'h0,    16'h002C, 1'b0, 1'b1};
        tbl[3]  = '{1, 2'd1, 32'hF800, 16'h0,    6,  5, 2, 0, 5,
                    32'h0,    16'hF800, 1'b1, 1'b1};
        tbl[4]  = '{1, 2'd1, 32'h001F, 16'h0,    6,  5, 2, 0, 5,
                    32'h0,    16'h001F, 1'b1, 1'b1};
        tbl[5]  = '{0, 2'd2, 32'h0,    16'h9341, 15, 14, 0, 8, 0,
                    32'h9341, 16'h0,    1'b1, 1'b1};
        tbl[6]  = '{0, 2'd0, 32'h0,    16'h5A5A, 1,  0, 0, 0, 0,
                    32'h0,    16'h0,    1'b0, 1'b1};
        tbl[7]  = '{1, 2'd2, 32'hABCD, 16'h0,    1,  0, 0, 0, 0,
                    32'h0,    16'h0,    1'b0, 1'b1};
        tbl[8]  = '{0, 2'd2, 32'h0,    16'h1234, 15, 14, 0, 8, 0,
                    32'h1234, 16'h0,    1'b1, 1'b1};
        tbl[9]  = '{1, 2'd3, 32'h0,    16'h0,    1,  0, 0, 0, 0,
                    32'h0,    16'h0,    1'b0, 1'b0};
        tbl[10] = '{0, 2'd3, 32'h0,    16'h0,    1,  0, 0, 0, 0,
                    32'h0,    16'h0,    1'b0, 1'b0};

        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle cs_n", 32'(lcd_cs_n), 32'd1);
        chk("idle rs", 32'(lcd_rs), 32'd1);
        chk("idle wr_n", 32'(lcd_wr_n), 32'd1);
        chk("idle rd_n", 32'(lcd_rd_n), 32'd1);
        chk("idle rst_n", 32'(lcd_rst_n), 32'd0);
        chk("idle data", 32'(lcd_data_out), 32'd0);
        chk("idle oe", 32'(lcd_data_oe), 32'd0);
        chk("idle waitreq", 32'(bus.waitrequest), 32'd0);
        chk("idle rdata", bus.readdata, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back accesses: each starts the cycle after the last DONE.
        for (int i = 0; i < 11; i++) begin
            access(tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].din, o);
            check_obs($sformatf("tbl%0d", i), o, tbl[i]);
        end
        rst_model = 1'b0;

        v = model(1'b1, 2'd3, 32'h1, 16'h0);
        access(v.wr, v.a, v.wd, v.din, o);
        check_obs("pre_rst", o, v);

        // Reset asserted while the write strobe is low.
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.read_n     = 1'b1;
        bus.address    = 2'd1;
        bus.writedata  = 32'h5555;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                if (!lcd_wr_n) seen = 1'b1;
            end
            chk("midrst strobe seen", 32'(seen), 32'd1);
        end
        #2 reset = 1'b1;
        #1;
        chk("midrst wr_n", 32'(lcd_wr_n), 32'd1);
        chk("midrst cs_n", 32'(lcd_cs_n), 32'd1);
        chk("midrst oe", 32'(lcd_data_oe), 32'd0);
        chk("midrst rst_n", 32'(lcd_rst_n), 32'd0);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        rst_model = 1'b0;
        @(negedge clk);
        chk("midrst waitreq", 32'(bus.waitrequest), 32'd0);
        chk("midrst cs_n idle", 32'(lcd_cs_n), 32'd1);
        @(posedge clk);
        #1;
        v = model(1'b1, 2'd1, 32'hBEEF, 16'h0);
        access(v.wr, v.a, v.wd, v.din, o);
        check_obs("post_rst", o, v);

        for (int i = 0; i < 40; i++) begin
            bit          wr;
            logic [1:0]  a;
            logic [31:0] wd;
            logic [15:0] din;
            wr  = 1'($urandom_range(0, 1));
            a   = 2'($urandom_range(0, 3));
            wd  = $urandom;
            din = 16'($urandom);
            v = model(wr, a, wd, din);
            access(v.wr, v.a, v.wd, v.din, o);
            check_obs($sformatf("rnd%0d", i), o, v);
            if ($urandom_range(0, 2) == 0) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
